// File: rtl/nco_sine_source.sv
// -----------------------------------------------------------------------------
// nco_sine_source
//
// Purpose
//   Numerically controlled oscillator feeding the sigma-delta DAC. Each
//   sample_req advances a 24-bit phase accumulator by the frequency control
//   word and returns one 10-bit offset-binary sine sample. The top byte of the
//   pre-add phase addresses the sine table.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous, active-low reset
//   fcw          in   frequency control word (0 = hold phase)
//   sample_req   in   one-cycle request strobe, may be high every cycle
//   phase_clr    in   synchronous phase clear (note change)
//   sample       out  sine sample, offset binary, held between updates
//   sample_valid out  one-cycle pulse when sample was updated
//
// Build option
//   QUARTER_WAVE_LUT_EN  defined: store only the first quarter wave and
//                        rebuild the other three with an extra mirror/invert
//                        register stage (request->valid latency 3).
//                        undefined: full 256-entry table (latency 2).
//   Output values are identical in both builds.
// -----------------------------------------------------------------------------
module nco_sine_source #(
    parameter int FCW_WIDTH    = 24,
    parameter int ADDR_WIDTH   = 8,
    parameter int SAMPLE_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FCW_WIDTH-1:0]    fcw,
    input  logic                    sample_req,
    input  logic                    phase_clr,
    output logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    sample_valid
);

    localparam int QTR_AW    = ADDR_WIDTH - 2;
    localparam int QTR_DEPTH = 2 ** QTR_AW;

    localparam logic [SAMPLE_WIDTH-1:0] FULL_SCALE = '1;
    localparam logic [SAMPLE_WIDTH-1:0] MID_SCALE  = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    // pi in Q30 fixed point, used only while elaborating the table.
    localparam longint PI_Q30 = 64'sd3373259426;

    // Quarter-wave table entry i: round(FS/2 + FS/2 * sin(2*pi*(i+0.5)/N)).
    // The half-step offset keeps the table symmetric so that mirroring and
    // inverting it reproduces the full period exactly. Evaluated at
    // elaboration with a Q30 Taylor series (x <= pi/2, 8 terms).
    function automatic logic [SAMPLE_WIDTH-1:0] quarter_sample(input int i);
        longint x;
        longint x2;
        longint term;
        longint sine;
        longint acc;
        x    = (PI_Q30 * longint'(2 * i + 1)) >>> ADDR_WIDTH;
        x2   = (x * x) >>> 30;
        term = x;
        sine = x;
        for (int k = 1; k <= 8; k++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            sine = sine + term;
        end
        // (FS*(1+s) + 1) / 2, floored: round-half-up of FS/2*(1+s)
        acc = (longint'(FULL_SCALE) <<< 30) + longint'(FULL_SCALE) * sine
            + (64'sd1 <<< 30);
        return SAMPLE_WIDTH'(acc >>> 31);
    endfunction

    // Second and fourth quarters read the quarter table backwards.
    // For a power-of-two quarter, (QTR_DEPTH-1) - j is simply ~j.
    function automatic logic [QTR_AW-1:0] mirror_index(input logic [ADDR_WIDTH-1:0] k);
        return k[ADDR_WIDTH-2] ? ~k[QTR_AW-1:0] : k[QTR_AW-1:0];
    endfunction

    // Second half of the period is the first half reflected about mid-scale.
    function automatic logic [SAMPLE_WIDTH-1:0] invert_half(
        input logic                    neg,
        input logic [SAMPLE_WIDTH-1:0] v
    );
        return neg ? (FULL_SCALE - v) : v;
    endfunction

    // -------------------------------------------------------------------------
    // Phase accumulator with fcw shadow.
    // The architectural phase is phase_acc + fcw_shadow: the step captured at
    // a request is applied at the next request. This keeps the fcw port
    // feeding only a register, and the adder sees two local registers.
    // -------------------------------------------------------------------------
    logic [FCW_WIDTH-1:0]  phase_acc;
    logic [FCW_WIDTH-1:0]  fcw_shadow;
    logic [FCW_WIDTH-1:0]  phase_sum;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic                  vld_p0;

    assign phase_sum = phase_acc + fcw_shadow;  // mod 2^FCW_WIDTH, silent wrap

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_acc  <= '0;
            fcw_shadow <= '0;
            vld_p0     <= 1'b0;
        end else begin
            vld_p0 <= sample_req;
            if (phase_clr) begin
                // With a request the new phase becomes fcw, otherwise zero.
                phase_acc  <= '0;
                fcw_shadow <= sample_req ? fcw : '0;
            end else if (sample_req) begin
                phase_acc  <= phase_sum;
                fcw_shadow <= fcw;
            end
        end
    end

    // ---- S0: request registers table address (pre-add phase, 0 on clear) ----
    always_ff @(posedge clk) begin
        if (sample_req) begin
            addr_p0 <= phase_clr ? '0 : phase_sum[FCW_WIDTH-1 -: ADDR_WIDTH];
        end
    end

`ifdef QUARTER_WAVE_LUT_EN

    logic [SAMPLE_WIDTH-1:0] qtr_rom [QTR_DEPTH];

    for (genvar g = 0; g < QTR_DEPTH; g++) begin : g_qtr_rom
        localparam logic [SAMPLE_WIDTH-1:0] ENTRY = quarter_sample(g);
        assign qtr_rom[g] = ENTRY;
    end

    logic [SAMPLE_WIDTH-1:0] q_p1;
    logic                    neg_p1;
    logic                    vld_p1;

    // ---- S1: registered quarter-table read, half select carried along ----
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            q_p1   <= qtr_rom[mirror_index(addr_p0)];
            neg_p1 <= addr_p0[ADDR_WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    // ---- S2: invert lower half, load output sample ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= MID_SCALE;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= vld_p1;
            if (vld_p1) begin
                sample <= invert_half(neg_p1, q_p1);
            end
        end
    end

`else

    // Full period built from the quarter rule so both builds agree bit-for-bit.
    function automatic logic [SAMPLE_WIDTH-1:0] full_sample(input int k);
        logic [ADDR_WIDTH-1:0] kk;
        kk = ADDR_WIDTH'(k);
        return invert_half(kk[ADDR_WIDTH-1], quarter_sample(int'(mirror_index(kk))));
    endfunction

    logic [SAMPLE_WIDTH-1:0] full_rom [2**ADDR_WIDTH];

    for (genvar g = 0; g < 2**ADDR_WIDTH; g++) begin : g_full_rom
        localparam logic [SAMPLE_WIDTH-1:0] ENTRY = full_sample(g);
        assign full_rom[g] = ENTRY;
    end

    // ---- S1/S2: registered table read straight into the output sample ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= MID_SCALE;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= vld_p0;
            if (vld_p0) begin
                sample <= full_rom[addr_p0];
            end
        end
    end

`endif

endmodule

// File: tb/tb_nco_sine_source.sv
// -----------------------------------------------------------------------------
// tb_nco_sine_source
//
// Self-checking bench for nco_sine_source. A reference model tracks the
// phase as a plain integer, computes each sample directly from the sine
// formula and keeps a queue of pending samples with their due cycle.
// Directed sequences add fixed expected values on top of the model.
// -----------------------------------------------------------------------------
module tb_nco_sine_source;

`ifdef QUARTER_WAVE_LUT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam real PI = 3.14159265358979323846;

    logic        clk;
    logic        rst_n;
    logic [23:0] fcw;
    logic        sample_req;
    logic        phase_clr;
    logic [9:0]  sample;
    logic        sample_valid;

    nco_sine_source dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fcw          (fcw),
        .sample_req   (sample_req),
        .phase_clr    (phase_clr),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int unsigned ph = 0;
    int          cyc = 0;
    int          exp_sample = 512;
    int          due_q[$];
    int          val_q[$];
    int          got_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Sample at table index k, straight from the sine definition.
    function automatic int ref_sample(input int k);
        real a;
        a = 2.0 * PI * (real'(k) + 0.5) / 256.0;
        return $rtoi($floor(511.5 + 511.5 * $sin(a) + 0.5));
    endfunction

    // Called just after the falling edge, inputs still as sampled at the
    // preceding rising edge.
    task automatic model_step(input logic req, input logic clr, input logic [23:0] f);
        int exp_v;
        int idx;
        cyc++;
        if (!rst_n) begin
            due_q.delete();
            val_q.delete();
            ph         = 0;
            exp_sample = 512;
        end else if (req) begin
            idx = clr ? 0 : int'((ph >> 16) & 32'hFF);
            due_q.push_back(cyc + LAT - 1);
            val_q.push_back(ref_sample(idx));
            ph = clr ? int'(f) : ((ph + int'(f)) & 32'hFF_FFFF);
        end else if (clr) begin
            ph = 0;
        end
        exp_v = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_v      = 1;
            exp_sample = val_q[0];
            void'(due_q.pop_front());
            void'(val_q.pop_front());
        end
        chk("sample_valid", int'(sample_valid), exp_v);
        chk("sample", int'(sample), exp_sample);
        if (sample_valid) got_q.push_back(int'(sample));
    endtask

    task automatic cycle(input logic req, input logic clr, input logic [23:0] f);
        sample_req = req;
        phase_clr  = clr;
        fcw        = f;
        @(posedge clk);
        @(negedge clk);
        model_step(req, clr, f);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, fcw);
    endtask

    initial begin
        int exp4[4];
        logic [23:0] rf;
        exp4 = '{518, 1023, 505, 0};

        rst_n      = 1'b0;
        sample_req = 1'b0;
        phase_clr  = 1'b0;
        fcw        = '0;
        @(negedge clk);

        // reset with request toggling
        for (int i = 0; i < 4; i++) cycle(i[0], 1'b0, 24'h400000);
        rst_n = 1'b1;
        idle(3);

        // quarter points
        got_q.delete();
        cycle(1'b1, 1'b1, 24'h400000);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 24'h400000);
        idle(LAT + 1);
        chk("quarter_count", got_q.size(), 4);
        if (got_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("quarter_value", got_q[i], exp4[i]);

        // full sweep, back-to-back
        got_q.delete();
        cycle(1'b1, 1'b1, 24'h010000);
        for (int i = 1; i < 256; i++) cycle(1'b1, 1'b0, 24'h010000);
        idle(LAT + 1);
        chk("sweep_count", got_q.size(), 256);
        if (got_q.size() == 256) begin
            chk("sweep_idx0", got_q[0], 518);
            chk("sweep_idx64", got_q[64], 1023);
            chk("sweep_idx128", got_q[128], 505);
            chk("sweep_idx192", got_q[192], 0);
        end
        got_q.delete();
        cycle(1'b1, 1'b0, 24'h000000);
        idle(LAT);
        chk("sweep_wrap_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("sweep_wrap_to_0", got_q[0], 518);

        // accumulator wrap
        got_q.delete();
        cycle(1'b1, 1'b1, 24'hFF0000);
        cycle(1'b1, 1'b0, 24'h020000);
        cycle(1'b1, 1'b0, 24'h020000);
        idle(LAT + 1);
        chk("wrap_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("wrap_idx_ff", got_q[1], 505);
            chk("wrap_idx_01", got_q[2], 530);
        end

        // fcw = 0 holds phase; fcw changes between requests are ignored
        got_q.delete();
        cycle(1'b1, 1'b1, 24'h400000);
        cycle(1'b1, 1'b0, 24'd0);
        cycle(1'b0, 1'b0, 24'd67934);
        cycle(1'b1, 1'b0, 24'd0);
        cycle(1'b0, 1'b0, 24'd67934);
        cycle(1'b0, 1'b0, 24'd0);
        cycle(1'b1, 1'b0, 24'd67934);
        cycle(1'b1, 1'b0, 24'd0);
        idle(LAT + 1);
        chk("hold_count", got_q.size(), 5);
        if (got_q.size() == 5) begin
            for (int i = 1; i < 4; i++) chk("hold_value", got_q[i], 1023);
            chk("hold_after_step", got_q[4], ref_sample(65));
        end

        // async reset right after a request drops it
        got_q.delete();
        cycle(1'b1, 1'b1, 24'h400000);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sample", int'(sample), 512);
        cycle(1'b1, 1'b0, 24'h400000);
        cycle(1'b0, 1'b0, 24'h400000);
        rst_n = 1'b1;
        idle(LAT + 1);
        chk("async_rst_no_valid", got_q.size(), 0);
        cycle(1'b1, 1'b0, 24'h400000);
        idle(LAT);
        chk("post_rst_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("post_rst_phase0", got_q[0], 518);

        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rf = 24'($urandom);
                1:       rf = 24'($urandom_range(0, 24'h03FFFF));
                2:       rf = 24'h0;
                default: rf = fcw;
            endcase
            rst_n = ($urandom_range(0, 299) != 0);
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rf);
        end
        rst_n = 1'b1;
        idle(LAT + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
